ip_memtest: RTL and testbench

Parametrised SDRAM pattern tester and the successor of the fixed-row tester inside ip_debugger. It drives the byte/word handshake of ip_sdram (rd/wr/busy/address/wdata/rdata/rdata_en). It writes a selectable pattern over a runtime address range, reads the range back and compares. It reports pass/fail, a saturating error count and the first-failure capture, which the debugger prints over ip_uart.

---
 rtl/ip_memtest_pkg.sv | 32 +++
 rtl/ip_memtest_if.sv | 37 +++
 rtl/ip_memtest_patgen.sv | 64 ++++++
 rtl/ip_memtest.sv | 273 +++++++++++++++++++++++++++
 tb/tb_ip_memtest.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ip_memtest_pkg.sv
// Shared types and helpers for the SDRAM pattern tester.
//   mode_e      : pattern selector encoding (matches the 2-bit mode input)
//   state_e     : sequencer FSM states
//   LFSR_POLY   : Galois LFSR feedback mask (right-shifting form)
//   lfsr_next() : one LFSR step
package ip_memtest_pkg;

    typedef enum logic [1:0] {
        MODE_INC  = 2'd0,
        MODE_LFSR = 2'd1,
        MODE_WALK = 2'd2,
        MODE_INV  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StWrIssue,
        StWrWait,
        StRdIssue,
        StRdWait,
        StFinish
    } state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Shift right; when a one falls out of bit 0, fold the feedback mask back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/ip_memtest_if.sv
// Byte/word request bus between the tester and the SDRAM controller.
//   master : tester side   (drives mem_rd, mem_wr, mem_address, mem_wdata)
//   slave  : memory side   (drives mem_busy, mem_rdata, mem_rdata_en)
interface ip_memtest_if #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned DATA_W = 8
) ();

    logic              mem_rd;
    logic              mem_wr;
    logic              mem_busy;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdata_en;

    modport master (
        output mem_rd,
        output mem_wr,
        output mem_address,
        output mem_wdata,
        input  mem_busy,
        input  mem_rdata,
        input  mem_rdata_en
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        input  mem_address,
        input  mem_wdata,
        output mem_busy,
        output mem_rdata,
        output mem_rdata_en
    );

endinterface

// File: rtl/ip_memtest_patgen.sv
// Test-pattern generator. Holds the LFSR and the offset-from-start counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : restart the sequence (LFSR <- seed or 1, offset <- 0)
//   step       : advance to the next address
//   mode       : pattern selector
//   seed       : LFSR seed / increment base
//   addr       : current address (used by the inverted-address pattern)
//   pattern    : data for the current address, combinational
module ip_memtest_patgen
    import ip_memtest_pkg::*;
#(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  mode_e             mode,
    input  logic [31:0]       seed,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pattern
);

    localparam int unsigned OFS_W = $clog2(DATA_W);

    logic [31:0]       lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] offset_q, offset_d;

    always_comb begin
        lfsr_d   = lfsr_q;
        offset_d = offset_q;
        if (load) begin
            // An all-zero LFSR would lock up, so a zero seed runs from 1.
            lfsr_d   = (seed == 32'd0) ? 32'd1 : seed;
            offset_d = '0;
        end else if (step) begin
            lfsr_d   = lfsr_next(lfsr_q);
            offset_d = offset_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q   <= '0;
            offset_q <= '0;
        end else begin
            lfsr_q   <= lfsr_d;
            offset_q <= offset_d;
        end
    end

    always_comb begin
        pattern = '0;
        case (mode)
            MODE_INC:  pattern = DATA_W'(seed + 32'(offset_q));
            MODE_LFSR: pattern = DATA_W'(lfsr_q);
            MODE_WALK: pattern = DATA_W'(1) << offset_q[OFS_W-1:0];
            MODE_INV:  pattern = DATA_W'(~addr);
            default:   pattern = '0;
        endcase
    end

endmodule

// File: rtl/ip_memtest.sv
// SDRAM pattern tester: writes a pattern over [start_addr, end_addr], reads it
// back, compares, and reports pass/fail, a saturating error count and the first
// failure.
//   clk, reset             : clock, synchronous active-high reset
//   start, abort           : begin a test (pulse, idle only) / stop it (level)
//   mode, seed             : pattern selector and its seed/base
//   start_addr, end_addr   : inclusive address range
//   mem                    : request bus to the SDRAM controller (master side)
//   running, done, pass    : status; done is a one-cycle pulse at test end
//   range_err, aborted     : latched end-condition flags
//   err_count, fail_*      : error statistics and first-failure capture
module ip_memtest
    import ip_memtest_pkg::*;
#(
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ERRC_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [31:0]       seed,
    ip_memtest_if.master      mem,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              range_err,
    output logic              aborted,
    output logic [ERRC_W-1:0] err_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic              fail_timeout
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [31:0]       seed_q, seed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              first_q, first_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ERRC_W-1:0] err_count_q, err_count_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_got_q, fail_got_d;
    logic              fail_timeout_q, fail_timeout_d;
    logic              pass_q, pass_d;
    logic              range_err_q, range_err_d;
    logic              aborted_q, aborted_d;

    logic              gen_load, gen_step;
    logic              wr_req, rd_req;
    logic              advance, err_hit, err_tmo;
    logic [DATA_W-1:0] err_got;
    logic [DATA_W-1:0] pattern;

    ip_memtest_patgen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_patgen (
        .clk     (clk),
        .reset   (reset),
        .load    (gen_load),
        .step    (gen_step),
        .mode    (mode_q),
        .seed    (seed_q),
        .addr    (addr_q),
        .pattern (pattern)
    );

    assign running = (state_q != StIdle) && (state_q != StFinish);
    assign done    = (state_q == StFinish);

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        start_d        = start_q;
        end_d          = end_q;
        seed_d         = seed_q;
        addr_d         = addr_q;
        first_d        = first_q;
        tmo_d          = tmo_q;
        err_count_d    = err_count_q;
        fail_addr_d    = fail_addr_q;
        fail_exp_d     = fail_exp_q;
        fail_got_d     = fail_got_q;
        fail_timeout_d = fail_timeout_q;
        pass_d         = pass_q;
        range_err_d    = range_err_q;
        aborted_d      = aborted_q;
        gen_load       = 1'b0;
        gen_step       = 1'b0;
        wr_req         = 1'b0;
        rd_req         = 1'b0;
        advance        = 1'b0;
        err_hit        = 1'b0;
        err_tmo        = 1'b0;
        err_got        = '0;

        // Abort preempts every running state, so no request is issued that cycle.
        if (running && abort) begin
            aborted_d = 1'b1;
            state_d   = StFinish;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_d         = mode_e'(mode);
                        start_d        = start_addr;
                        end_d          = end_addr;
                        seed_d         = seed;
                        err_count_d    = '0;
                        fail_addr_d    = '0;
                        fail_exp_d     = '0;
                        fail_got_d     = '0;
                        fail_timeout_d = 1'b0;
                        pass_d         = 1'b0;
                        range_err_d    = 1'b0;
                        aborted_d      = 1'b0;
                        state_d        = StCheck;
                    end
                end
                StCheck: begin
                    if (end_q < start_q) begin
                        range_err_d = 1'b1;
                        state_d     = StFinish;
                    end else begin
                        addr_d   = start_q;
                        gen_load = 1'b1;
                        state_d  = StWrIssue;
                    end
                end
                StWrIssue: begin
                    if (!mem.mem_busy) begin
                        wr_req  = 1'b1;
                        first_d = 1'b1;
                        state_d = StWrWait;
                    end
                end
                StWrWait: begin
                    // The controller may not raise busy until the cycle after the request.
                    if (first_q) begin
                        first_d = 1'b0;
                    end else if (!mem.mem_busy) begin
                        if (addr_q == end_q) begin
                            addr_d   = start_q;
                            gen_load = 1'b1;
                            state_d  = StRdIssue;
                        end else begin
                            addr_d   = addr_q + ADDR_W'(1);
                            gen_step = 1'b1;
                            state_d  = StWrIssue;
                        end
                    end
                end
                StRdIssue: begin
                    if (!mem.mem_busy) begin
                        rd_req  = 1'b1;
                        tmo_d   = '0;
                        state_d = StRdWait;
                    end
                end
                StRdWait: begin
                    if (mem.mem_rdata_en) begin
                        advance = 1'b1;
                        if (mem.mem_rdata != pattern) begin
                            err_hit = 1'b1;
                            err_got = mem.mem_rdata;
                        end
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        advance = 1'b1;
                        err_hit = 1'b1;
                        err_tmo = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                    if (advance) begin
                        if (addr_q == end_q) begin
                            state_d = StFinish;
                        end else begin
                            addr_d   = addr_q + ADDR_W'(1);
                            gen_step = 1'b1;
                            state_d  = StRdIssue;
                        end
                    end
                end
                StFinish: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end

        if (err_hit) begin
            // A zero count means this is the first failure of the test.
            if (err_count_q == '0) begin
                fail_addr_d    = addr_q;
                fail_exp_d     = pattern;
                fail_got_d     = err_got;
                fail_timeout_d = err_tmo;
            end
            if (err_count_q != {ERRC_W{1'b1}}) begin
                err_count_d = err_count_q + ERRC_W'(1);
            end
        end

        // Resolve pass on entry to FINISH so it is already valid during done.
        if (state_d == StFinish && state_q != StFinish) begin
            pass_d = (err_count_d == '0) && !range_err_d && !aborted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            mode_q         <= MODE_INC;
            start_q        <= '0;
            end_q          <= '0;
            seed_q         <= '0;
            addr_q         <= '0;
            first_q        <= 1'b0;
            tmo_q          <= '0;
            err_count_q    <= '0;
            fail_addr_q    <= '0;
            fail_exp_q     <= '0;
            fail_got_q     <= '0;
            fail_timeout_q <= 1'b0;
            pass_q         <= 1'b0;
            range_err_q    <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            start_q        <= start_d;
            end_q          <= end_d;
            seed_q         <= seed_d;
            addr_q         <= addr_d;
            first_q        <= first_d;
            tmo_q          <= tmo_d;
            err_count_q    <= err_count_d;
            fail_addr_q    <= fail_addr_d;
            fail_exp_q     <= fail_exp_d;
            fail_got_q     <= fail_got_d;
            fail_timeout_q <= fail_timeout_d;
            pass_q         <= pass_d;
            range_err_q    <= range_err_d;
            aborted_q      <= aborted_d;
        end
    end

    // Requests are gated by reset so an in-flight request drops in the reset cycle.
    assign mem.mem_wr      = wr_req && !reset;
    assign mem.mem_rd      = rd_req && !reset;
    assign mem.mem_address = addr_q;
    assign mem.mem_wdata   = pattern;

    assign pass         = pass_q;
    assign range_err    = range_err_q;
    assign aborted      = aborted_q;
    assign err_count    = err_count_q;
    assign fail_addr    = fail_addr_q;
    assign fail_exp     = fail_exp_q;
    assign fail_got     = fail_got_q;
    assign fail_timeout = fail_timeout_q;

endmodule

// File: tb/tb_ip_memtest.sv
module tb_ip_memtest;

    localparam int unsigned AW = 23;
    localparam int unsigned DW = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [1:0]    mode;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic [31:0]   seed;
    logic          running, done, pass, range_err, aborted, fail_timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_got;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cnt  = 0;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    logic          stuck_en  = 1'b0;
    logic          noresp_en = 1'b0;

    ip_memtest_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

    ip_memtest #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .ERRC_W  (16),
        .TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .seed         (seed),
        .mem          (mif),
        .running      (running),
        .done         (done),
        .pass         (pass),
        .range_err    (range_err),
        .aborted      (aborted),
        .err_count    (err_count),
        .fail_addr    (fail_addr),
        .fail_exp     (fail_exp),
        .fail_got     (fail_got),
        .fail_timeout (fail_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    // Memory stub: samples requests at negedge (scoreboard pop), answers after the edge.
    initial begin : mem_stub
        logic          wr_s, rd_s, rd_pend;
        logic [AW-1:0] a_s, rd_a, ra;
        logic [DW-1:0] d_s;
        int            busy_cnt;
        wr_t           e;
        mif.mem_busy     = 1'b0;
        mif.mem_rdata    = '0;
        mif.mem_rdata_en = 1'b0;
        busy_cnt = 0;
        rd_pend  = 1'b0;
        rd_a     = '0;
        forever begin
            @(negedge clk);
            wr_s = mif.mem_wr;
            rd_s = mif.mem_rd;
            a_s  = mif.mem_address;
            d_s  = mif.mem_wdata;
            if (wr_s) begin
                req_cnt++;
                chk("wr_expected", 64'(exp_wr.size() != 0), 64'(1));
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(a_s), 64'(e.addr));
                    chk("wr_data", 64'(d_s), 64'(e.data));
                end
            end
            if (rd_s) begin
                req_cnt++;
                chk("rd_expected", 64'(exp_rd.size() != 0), 64'(1));
                if (exp_rd.size() != 0) begin
                    ra = exp_rd.pop_front();
                    chk("rd_addr", 64'(a_s), 64'(ra));
                end
            end
            @(posedge clk);
            #1;
            mif.mem_rdata_en = 1'b0;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    mif.mem_busy = 1'b0;
                    if (rd_pend) begin
                        rd_pend = 1'b0;
                        if (!(noresp_en && rd_a == AW'(2))) begin
                            mif.mem_rdata    = mem_model.exists(rd_a) ? mem_model[rd_a] : '0;
                            mif.mem_rdata_en = 1'b1;
                        end
                    end
                end
            end
            if (wr_s) begin
                mem_model[a_s] = (stuck_en && a_s == AW'(3)) ? (d_s & 8'hF7) : d_s;
                mif.mem_busy   = 1'b1;
                busy_cnt       = 2;
            end
            if (rd_s) begin
                mif.mem_busy = 1'b1;
                busy_cnt     = 3;
                rd_pend      = 1'b1;
                rd_a         = a_s;
            end
        end
    end

    task automatic check_idle(input string pfx);
        chk({pfx, "_running"}, 64'(running), 64'(0));
        chk({pfx, "_done"}, 64'(done), 64'(0));
        chk({pfx, "_pass"}, 64'(pass), 64'(0));
        chk({pfx, "_range_err"}, 64'(range_err), 64'(0));
        chk({pfx, "_aborted"}, 64'(aborted), 64'(0));
        chk({pfx, "_err_count"}, 64'(err_count), 64'(0));
        chk({pfx, "_fail_addr"}, 64'(fail_addr), 64'(0));
        chk({pfx, "_fail_exp"}, 64'(fail_exp), 64'(0));
        chk({pfx, "_fail_got"}, 64'(fail_got), 64'(0));
        chk({pfx, "_fail_timeout"}, 64'(fail_timeout), 64'(0));
        chk({pfx, "_mem_rd"}, 64'(mif.mem_rd), 64'(0));
        chk({pfx, "_mem_wr"}, 64'(mif.mem_wr), 64'(0));
        chk({pfx, "_mem_address"}, 64'(mif.mem_address), 64'(0));
        chk({pfx, "_mem_wdata"}, 64'(mif.mem_wdata), 64'(0));
    endtask

    // Push the expected write/read stream for the range, then pulse start.
    task automatic launch(input logic [1:0] m, input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                          input logic [31:0] sd);
        logic [31:0]   lf;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        exp_wr.delete();
        exp_rd.delete();
        if (ea >= sa) begin
            lf = (sd == 32'd0) ? 32'd1 : sd;
            for (int i = 0; i <= int'(ea - sa); i++) begin
                a = sa + AW'(i);
                case (m)
                    2'd0:    d = 8'(sd + 32'(i));
                    2'd1:    d = lf[7:0];
                    2'd2:    d = 8'(1) << (i % 8);
                    default: d = 8'(~a);
                endcase
                exp_wr.push_back('{a, d});
                exp_rd.push_back(a);
                lf = lfsr_step(lf);
            end
        end
        @(negedge clk);
        mode       = m;
        start_addr = sa;
        end_addr   = ea;
        seed       = sd;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic check_result(input string tag, input logic ep, input int ee,
                                input logic [AW-1:0] ea, input logic [DW-1:0] ex,
                                input logic [DW-1:0] eg, input logic et);
        chk({tag, "_pass"}, 64'(pass), 64'(ep));
        chk({tag, "_err_count"}, 64'(err_count), 64'(ee));
        chk({tag, "_fail_addr"}, 64'(fail_addr), 64'(ea));
        chk({tag, "_fail_exp"}, 64'(fail_exp), 64'(ex));
        chk({tag, "_fail_got"}, 64'(fail_got), 64'(eg));
        chk({tag, "_fail_timeout"}, 64'(fail_timeout), 64'(et));
        chk({tag, "_wr_left"}, 64'(exp_wr.size()), 64'(0));
        chk({tag, "_rd_left"}, 64'(exp_rd.size()), 64'(0));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'(0));
        chk({tag, "_pass_held"}, 64'(pass), 64'(ep));
    endtask

    initial begin : main
        int n, k, rc0;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        mode       = 2'd0;
        start_addr = '0;
        end_addr   = '0;
        seed       = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        // Increment pattern: writes 0x10..0x1F
        launch(2'd0, AW'(0), AW'('h0F), 32'h10);
        wait_done("inc", 2000);
        check_result("inc", 1'b1, 0, '0, '0, '0, 1'b0);

        // LFSR with zero seed (runs from 1)
        launch(2'd1, AW'('h100), AW'('h1FF), 32'h0);
        wait_done("lfsr", 8000);
        check_result("lfsr", 1'b1, 0, '0, '0, '0, 1'b0);

        // Walking one with bit 3 stuck low at address 3
        stuck_en = 1'b1;
        launch(2'd2, AW'(0), AW'('h0F), 32'h0);
        wait_done("walk", 2000);
        check_result("walk", 1'b0, 1, AW'(3), 8'h08, 8'h00, 1'b0);
        stuck_en = 1'b0;

        // No read response at address 2
        noresp_en = 1'b1;
        launch(2'd3, AW'(0), AW'(7), 32'h0);
        wait_done("tmo", 2000);
        check_result("tmo", 1'b0, 1, AW'(2), 8'hFD, 8'h00, 1'b1);
        noresp_en = 1'b0;

        // Reversed range: done two cycles after start, no memory traffic
        rc0 = req_cnt;
        launch(2'd0, AW'('h10), AW'('h0F), 32'h0);
        chk("range_running", 64'(running), 64'(1));
        chk("range_early_done", 64'(done), 64'(0));
        @(negedge clk);
        chk("range_done", 64'(done), 64'(1));
        chk("range_err", 64'(range_err), 64'(1));
        chk("range_pass", 64'(pass), 64'(0));
        chk("range_err_count_cleared", 64'(err_count), 64'(0));
        chk("range_fail_timeout_cleared", 64'(fail_timeout), 64'(0));
        chk("range_no_requests", 64'(req_cnt - rc0), 64'(0));

        // Abort during the read pass
        launch(2'd0, AW'(0), AW'('h1F), 32'h0);
        n = 0;
        while (!mif.mem_rd && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_rd_seen", 64'(mif.mem_rd), 64'(1));
        @(negedge clk);
        abort = 1'b1;
        wait_done("abort", 10);
        abort = 1'b0;
        chk("abort_aborted", 64'(aborted), 64'(1));
        chk("abort_pass", 64'(pass), 64'(0));
        chk("abort_mem_rd", 64'(mif.mem_rd), 64'(0));
        chk("abort_mem_wr", 64'(mif.mem_wr), 64'(0));
        exp_wr.delete();
        exp_rd.delete();
        rc0 = req_cnt;
        repeat (10) @(negedge clk);
        chk("abort_quiet", 64'(req_cnt - rc0), 64'(0));
        chk("abort_idle", 64'(running), 64'(0));

        // Reset while a write request is on the bus
        launch(2'd0, AW'(0), AW'('h3F), 32'h40);
        n = 0;
        k = 0;
        while (k < 3 && n < 500) begin
            @(negedge clk);
            n++;
            if (mif.mem_wr) k++;
        end
        chk("rst_wr_seen", 64'(mif.mem_wr), 64'(1));
        reset = 1'b1;
        #1;
        chk("rst_drops_wr", 64'(mif.mem_wr), 64'(0));
        @(negedge clk);
        check_idle("midrst");
        @(negedge clk);
        reset = 1'b0;
        exp_wr.delete();
        exp_rd.delete();

        // Range ending at the top address must stop there, not wrap
        launch(2'd3, AW'('h7FFFFE), AW'('h7FFFFF), 32'h0);
        wait_done("top", 500);
        check_result("top", 1'b1, 0, '0, '0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
